sprite_draw: RTL and testbench

Sprite blitter that sits directly upstream of the ROM read stage and feeds its pixels to the LCD write path. It accepts one draw command at a time (sprite ROM id, screen position, size). It then walks the sprite's ROM addresses in row-major order and compensates for the two-cycle ROM read latency. Transparent and off-screen pixels are dropped; the rest are emitted as (x, y, colour) writes under a valid/ready handshake, with a small FIFO absorbing backpressure.

---
 rtl/sprite_draw.sv | 227 ++++++++++++++++++++++
 tb/tb_sprite_draw.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw.sv
// Sprite blitter feeding the LCD write path, with the small pixel FIFO it uses.

// Generic synchronous FIFO with the head word always visible on out_dat.
// Latency: a word pushed on one edge is presented from that edge on.
// Backpressure: head holds while out_rdy is low; the producer must never push when full.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_vld) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(in_vld) - CW'(pop);
        end
    end
endmodule

// Walks a sprite's ROM words row-major, drops transparent/off-screen pixels, emits (x,y,colour).
// Latency: first visible pixel is presented 3 edges after the command is accepted.
// Backpressure: pixelReady low stalls ROM fetches once fetches in flight plus buffered reach FIFO_DEPTH.
module sprite_draw #(
    parameter int          SCREEN_WIDTH  = 240,
    parameter int          SCREEN_HEIGHT = 320,
    parameter logic [15:0] TRANSPARENT   = 16'hF81F,
    parameter int          ROM_LATENCY   = 2,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        drawStart,
    output logic        drawReady,
    input  logic [3:0]  spriteId,
    input  logic [8:0]  spriteX,
    input  logic [8:0]  spriteY,
    input  logic [7:0]  spriteWidth,
    input  logic [8:0]  spriteHeight,
    output logic [3:0]  romId,
    output logic [15:0] romAddr,
    input  logic [15:0] romData,
    output logic [8:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady,
    output logic        drawDone
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t     state;
    logic [8:0] base_x;
    logic [8:0] base_y;
    logic [7:0] width;
    logic [8:0] height;
    logic [7:0] col;
    logic [8:0] row;

    // Stage 0 belongs to the address currently on romAddr; the last stage lines up with romData.
    logic       tag_vld [ROM_LATENCY+1];
    logic [9:0] tag_x   [ROM_LATENCY+1];
    logic [9:0] tag_y   [ROM_LATENCY+1];

    logic          ret_vld;
    logic          push_vld;
    pixel_t        push_dat;
    pixel_t        head;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic [7:0]    inflight;
    logic          credit;
    logic          drained;
    logic          wrap;
    logic [7:0]    col_next;
    logic [8:0]    row_next;
    logic          last_next;

    assign ret_vld  = tag_vld[ROM_LATENCY];
    assign push_vld = ret_vld && (romData != TRANSPARENT)
                      && (tag_x[ROM_LATENCY] < 10'(SCREEN_WIDTH))
                      && (tag_y[ROM_LATENCY] < 10'(SCREEN_HEIGHT));
    assign push_dat = {tag_x[ROM_LATENCY][8:0], tag_y[ROM_LATENCY][8:0], romData};
    assign pop      = pixelWrite && pixelReady;

    fifo #(.WIDTH($bits(pixel_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (push_vld),
        .in_dat  (push_dat),
        .out_vld (pixelWrite),
        .out_rdy (pixelReady),
        .out_dat (head),
        .count   (fifo_count)
    );

    assign pixelX    = head.x;
    assign pixelY    = head.y;
    assign pixelData = head.colour;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ROM_LATENCY; i++) inflight = inflight + 8'(tag_vld[i]);
    end

    // Same-cycle pops are deliberately not credited, so the FIFO can never overflow.
    assign credit  = (inflight + 8'(fifo_count)) < 8'(FIFO_DEPTH);
    // True when the coming edge retires the last fetch and leaves the FIFO empty.
    assign drained = (inflight == 8'(ret_vld))
                     && ((8'(fifo_count) + 8'(push_vld)) == 8'(pop));

    always_comb begin
        wrap      = (col == width - 8'd1);
        col_next  = wrap ? 8'd0 : col + 8'd1;
        row_next  = wrap ? row + 9'd1 : row;
        last_next = (col_next == width - 8'd1) && (row_next == height - 9'd1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drawReady <= 1'b1;
            drawDone  <= 1'b0;
            romId     <= '0;
            romAddr   <= '0;
            base_x    <= '0;
            base_y    <= '0;
            width     <= '0;
            height    <= '0;
            col       <= '0;
            row       <= '0;
            for (int i = 0; i <= ROM_LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_x[i]   <= '0;
                tag_y[i]   <= '0;
            end
        end else begin
            drawDone   <= 1'b0;
            tag_vld[0] <= 1'b0;
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_x[i]   <= tag_x[i-1];
                tag_y[i]   <= tag_y[i-1];
            end

            case (state)
                IDLE: begin
                    if (drawStart && drawReady) begin
                        drawReady <= 1'b0;
                        romId     <= spriteId;
                        base_x    <= spriteX;
                        base_y    <= spriteY;
                        width     <= spriteWidth;
                        height    <= spriteHeight;
                        col       <= '0;
                        row       <= '0;
                        if (spriteWidth == 8'd0 || spriteHeight == 9'd0) begin
                            state <= DONE;
                        end else begin
                            // Accepting the command presents address 0 as the first fetch.
                            romAddr    <= '0;
                            tag_vld[0] <= 1'b1;
                            tag_x[0]   <= {1'b0, spriteX};
                            tag_y[0]   <= {1'b0, spriteY};
                            state      <= (spriteWidth == 8'd1 && spriteHeight == 9'd1) ? DRAIN : FETCH;
                        end
                    end else begin
                        drawReady <= 1'b1;
                    end
                end
                FETCH: begin
                    if (credit) begin
                        romAddr    <= romAddr + 16'd1;
                        col        <= col_next;
                        row        <= row_next;
                        tag_vld[0] <= 1'b1;
                        tag_x[0]   <= {1'b0, base_x} + {2'b0, col_next};
                        tag_y[0]   <= {1'b0, base_y} + {1'b0, row_next};
                        if (last_next) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) state <= DONE;
                end
                DONE: begin
                    drawDone <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: ROM model, pixel scoreboard and per-command checks.
module tb_sprite_draw;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        drawStart = 1'b0;
    logic        drawReady;
    logic [3:0]  spriteId = '0;
    logic [8:0]  spriteX = '0;
    logic [8:0]  spriteY = '0;
    logic [7:0]  spriteWidth = '0;
    logic [8:0]  spriteHeight = '0;
    logic [3:0]  romId;
    logic [15:0] romAddr;
    logic [15:0] romData = '0;
    logic [8:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady = 1'b1;
    logic        drawDone;

    sprite_draw dut (
        .clock        (clock),
        .reset        (reset),
        .drawStart    (drawStart),
        .drawReady    (drawReady),
        .spriteId     (spriteId),
        .spriteX      (spriteX),
        .spriteY      (spriteY),
        .spriteWidth  (spriteWidth),
        .spriteHeight (spriteHeight),
        .romId        (romId),
        .romAddr      (romAddr),
        .romData      (romData),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .pixelData    (pixelData),
        .pixelWrite   (pixelWrite),
        .pixelReady   (pixelReady),
        .drawDone     (drawDone)
    );

    always #5 clock = ~clock;

    // Two-register ROM read stage.
    logic [15:0] rom [16];
    logic [15:0] rom_q;
    always @(posedge clock) begin
        rom_q   <= rom[romAddr[3:0]];
        romData <= rom_q;
    end

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } px_t;

    px_t exp_q[$];
    int  n_total = 0;
    int  n_bad = 0;
    int  n_writes = 0;
    int  n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_px(input int x, input int y, input logic [15:0] d);
        px_t p;
        p.x = 9'(x);
        p.y = 9'(y);
        p.d = d;
        exp_q.push_back(p);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic start_cmd(input int id, input int x, input int y, input int w, input int h);
        for (int k = 0; k < 100 && !drawReady; k++) tick();
        chk("ready_before_start", 32'(drawReady), 32'd1);
        spriteId     = 4'(id);
        spriteX      = 9'(x);
        spriteY      = 9'(y);
        spriteWidth  = 8'(w);
        spriteHeight = 9'(h);
        drawStart    = 1'b1;
        tick();
        drawStart    = 1'b0;
    endtask

    task automatic wait_done(input int exp_writes, input int w0, input int d0);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (drawDone) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        tick();
        chk("done_single_cycle", 32'(drawDone), 32'd0);
        chk("ready_after_done", 32'(drawReady), 32'd1);
        chk("write_count", 32'(n_writes - w0), 32'(exp_writes));
        chk("done_count", 32'(n_done - d0), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: the FIFO head must always match the next expected pixel.
    always @(negedge clock) begin
        if (!reset && pixelWrite) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_write: got (%0d,%0d,%h) want none", pixelX, pixelY, pixelData);
            end else begin
                chk("pixel_x", 32'(pixelX), 32'(exp_q[0].x));
                chk("pixel_y", 32'(pixelY), 32'(exp_q[0].y));
                chk("pixel_data", 32'(pixelData), 32'(exp_q[0].d));
                if (pixelReady) begin
                    exp_q.delete(0);
                    n_writes++;
                end
            end
        end
        if (!reset && drawDone) n_done++;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: time limit reached, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int lat;
        for (int i = 0; i < 16; i++) rom[i] = 16'hA000 + 16'(i);

        #2 reset = 1'b1;
        #1;
        chk("rst_drawReady", 32'(drawReady), 32'd1);
        chk("rst_drawDone", 32'(drawDone), 32'd0);
        chk("rst_pixelWrite", 32'(pixelWrite), 32'd0);
        chk("rst_romId", 32'(romId), 32'd0);
        chk("rst_romAddr", 32'(romAddr), 32'd0);
        chk("rst_pixelX", 32'(pixelX), 32'd0);
        chk("rst_pixelData", 32'(pixelData), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 2x2 opaque sprite
        w0 = n_writes; d0 = n_done;
        expect_px(10, 20, 16'hA000);
        expect_px(11, 20, 16'hA001);
        expect_px(10, 21, 16'hA002);
        expect_px(11, 21, 16'hA003);
        start_cmd(5, 10, 20, 2, 2);
        chk("accept_romAddr", 32'(romAddr), 32'd0);
        chk("accept_romId", 32'(romId), 32'd5);
        chk("accept_drawReady", 32'(drawReady), 32'd0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pixelWrite) begin
                lat = k;
                break;
            end
        end
        chk("first_write_latency", 32'(lat), 32'd3);
        wait_done(4, w0, d0);
        chk("final_romAddr_2x2", 32'(romAddr), 32'd3);

        // transparent word at address 1
        rom[1] = 16'hF81F;
        w0 = n_writes; d0 = n_done;
        expect_px(10, 20, 16'hA000);
        expect_px(10, 21, 16'hA002);
        expect_px(11, 21, 16'hA003);
        start_cmd(5, 10, 20, 2, 2);
        wait_done(3, w0, d0);
        rom[1] = 16'hA001;

        // right-edge clipping
        w0 = n_writes; d0 = n_done;
        expect_px(238, 0, 16'hA000);
        expect_px(239, 0, 16'hA001);
        start_cmd(1, 238, 0, 4, 1);
        wait_done(2, w0, d0);
        chk("final_romAddr_clip", 32'(romAddr), 32'd3);

        // bottom-edge clipping, nothing visible
        w0 = n_writes; d0 = n_done;
        start_cmd(1, 0, 320, 1, 1);
        wait_done(0, w0, d0);

        // 3x3 with output stalled from accept, plus an ignored busy command
        w0 = n_writes; d0 = n_done;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                expect_px(100 + c, 100 + r, 16'hA000 + 16'(r * 3 + c));
        pixelReady = 1'b0;
        start_cmd(3, 100, 100, 3, 3);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) begin
                spriteId = 4'd9; spriteWidth = 8'd1; spriteHeight = 9'd1; drawStart = 1'b1;
            end
            if (k == 5) drawStart = 1'b0;
        end
        chk("stall_romAddr_frozen", 32'(romAddr), 32'd3);
        chk("stall_pixelWrite", 32'(pixelWrite), 32'd1);
        chk("busy_romId_held", 32'(romId), 32'd3);
        pixelReady = 1'b1;
        wait_done(9, w0, d0);
        chk("final_romAddr_3x3", 32'(romAddr), 32'd8);

        // empty sprite
        w0 = n_writes; d0 = n_done;
        start_cmd(7, 5, 5, 0, 3);
        chk("empty_done_at_accept", 32'(drawDone), 32'd0);
        tick();
        chk("empty_done_pulse", 32'(drawDone), 32'd1);
        chk("empty_ready_low", 32'(drawReady), 32'd0);
        tick();
        chk("empty_done_cleared", 32'(drawDone), 32'd0);
        chk("empty_ready_back", 32'(drawReady), 32'd1);
        tick();
        chk("empty_romAddr_untouched", 32'(romAddr), 32'd8);
        chk("empty_write_count", 32'(n_writes - w0), 32'd0);
        chk("empty_done_count", 32'(n_done - d0), 32'd1);

        // asynchronous reset in the middle of a draw
        expect_px(10, 20, 16'hA000);
        expect_px(11, 20, 16'hA001);
        expect_px(10, 21, 16'hA002);
        expect_px(11, 21, 16'hA003);
        start_cmd(2, 10, 20, 2, 2);
        tick();
        tick();
        tick();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("midrst_romAddr", 32'(romAddr), 32'd0);
        chk("midrst_romId", 32'(romId), 32'd0);
        chk("midrst_pixelWrite", 32'(pixelWrite), 32'd0);
        chk("midrst_drawReady", 32'(drawReady), 32'd1);
        chk("midrst_pixelX", 32'(pixelX), 32'd0);
        chk("midrst_pixelY", 32'(pixelY), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();

        w0 = n_writes; d0 = n_done;
        expect_px(10, 20, 16'hA000);
        expect_px(11, 20, 16'hA001);
        expect_px(10, 21, 16'hA002);
        expect_px(11, 21, 16'hA003);
        start_cmd(6, 10, 20, 2, 2);
        wait_done(4, w0, d0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
